// File: rtl/cba_pkg.sv
// Shared codes, state encoding and helpers for the CB port-A read path.
package cba_pkg;

  localparam int CB_DOUTA_SEL_DW = 5;

  typedef enum logic [2:0] {
    CBA_IDLE = 3'b000,
    CBA_A    = 3'b001,
    CBA_B    = 3'b010,
    CBA_M    = 3'b011,
    CBA_TBA  = 3'b100,
    CBA_NL   = 3'b111
  } cba_op_e;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } cba_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } cba_state_e;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/cb_rd_align_pipe.sv
// RD_LAT-deep {valid, sel, seq} chain that lines read tags up with CB data.
module cb_rd_align_pipe #(
  parameter int RD_LAT = 2,
  parameter int SEL_DW = 5,
  parameter int SEQ_DW = 10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [SEL_DW-1:0] in_sel,
  input  logic [SEQ_DW-1:0] in_seq,
  output logic              out_valid,
  output logic [SEL_DW-1:0] out_sel,
  output logic [SEQ_DW-1:0] out_seq
);

  logic [RD_LAT-1:0]             v_r;
  logic [RD_LAT-1:0][SEL_DW-1:0] sel_r;
  logic [RD_LAT-1:0][SEQ_DW-1:0] seq_r;

  always_ff @(posedge clk) begin
    if (clr) begin
      v_r   <= '0;
      sel_r <= '0;
      seq_r <= '0;
    end else begin
      v_r[0]   <= in_valid;
      sel_r[0] <= in_sel;
      seq_r[0] <= in_seq;
      for (int i = 1; i < RD_LAT; i++) begin
        v_r[i]   <= v_r[i-1];
        sel_r[i] <= sel_r[i-1];
        seq_r[i] <= seq_r[i-1];
      end
    end
  end

  // Idle slots present zero so the mapper never sees a stale tag.
  assign out_valid = v_r[RD_LAT-1];
  assign out_sel   = out_valid ? sel_r[RD_LAT-1] : '0;
  assign out_seq   = out_valid ? seq_r[RD_LAT-1] : '0;

endmodule

// File: rtl/cba_rd_sched.sv
// Command-driven CB port-A read sequencer with latency-aligned mapper tags.
module cba_rd_sched #(
  parameter int CB_AW           = 10,
  parameter int SEQ_CNT_DW      = 10,
  parameter int CB_DOUTA_SEL_DW = cba_pkg::CB_DOUTA_SEL_DW,
  parameter int RD_LAT          = 2
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [1:0]                 cmd_dir,
  input  logic [CB_AW-1:0]           cmd_base,
  input  logic [SEQ_CNT_DW-1:0]      cmd_len,
  input  logic [SEQ_CNT_DW-1:0]      cmd_seq_start,
  input  logic                       cmd_l_k_0,
  output logic                       CB_ena,
  output logic [CB_AW-1:0]           CB_addra,
  output logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
  output logic [SEQ_CNT_DW-1:0]      seq_cnt_out,
  output logic                       l_k_0,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  import cba_pkg::*;

  cba_state_e state, state_nxt;

  logic [2:0]            op_r;
  logic [1:0]            dir_r;
  logic                  ill_r;
  logic [CB_AW-1:0]      base_r;
  logic [SEQ_CNT_DW-1:0] len_r;
  logic [SEQ_CNT_DW-1:0] seq0_r;
  logic [SEQ_CNT_DW-1:0] cnt;

  logic acc;
  logic last_rd;
  logic last_drn;

  logic                       p_valid;
  logic [CB_DOUTA_SEL_DW-1:0] p_sel;
  logic [SEQ_CNT_DW-1:0]      p_seq;
  logic                       q_valid;

  assign acc      = cmd_valid & cmd_ready;
  assign last_rd  = cnt == (len_r - 1'b1);
  assign last_drn = cnt == SEQ_CNT_DW'(RD_LAT - 1);

  always_ff @(posedge clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (acc) state_nxt = (cmd_len != '0) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (last_rd) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_drn) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The same counter walks read indices in ISSUE and latency slots in DRAIN.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      op_r   <= '0;
      dir_r  <= '0;
      ill_r  <= 1'b0;
      base_r <= '0;
      len_r  <= '0;
      seq0_r <= '0;
      l_k_0  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (acc) begin
        op_r   <= cmd_op;
        dir_r  <= cmd_dir;
        ill_r  <= is_illegal_op(cmd_op);
        base_r <= cmd_base;
        len_r  <= cmd_len;
        seq0_r <= cmd_seq_start;
        l_k_0  <= cmd_l_k_0;
      end
      if (acc || (state == ST_ISSUE && last_rd))
        cnt <= '0;
      else if (state == ST_ISSUE || state == ST_DRAIN)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) & ~sys_rst;
    busy      = state != ST_IDLE;
    done      = state == ST_DONE;
    err       = (state == ST_DONE) & ill_r;
    CB_ena    = state == ST_ISSUE;
    CB_addra  = '0;
    p_valid   = 1'b0;
    p_sel     = '0;
    p_seq     = '0;
    if (state == ST_ISSUE) begin
      CB_addra = base_r + CB_AW'(cnt);
      p_valid  = 1'b1;
      p_sel    = ill_r ? '0 : CB_DOUTA_SEL_DW'({op_r, dir_r});
      p_seq    = seq0_r + cnt;
    end
  end

  cb_rd_align_pipe #(
    .RD_LAT (RD_LAT),
    .SEL_DW (CB_DOUTA_SEL_DW),
    .SEQ_DW (SEQ_CNT_DW)
  ) u_align (
    .clk       (clk),
    .clr       (sys_rst),
    .in_valid  (p_valid),
    .in_sel    (p_sel),
    .in_seq    (p_seq),
    .out_valid (q_valid),
    .out_sel   (CB_douta_sel),
    .out_seq   (seq_cnt_out)
  );

  logic unused_ok;
  assign unused_ok = q_valid;

endmodule

// File: tb/tb_cba_rd_sched.sv
// Randomized and directed bench for cba_rd_sched against a cycle-offset model.
module tb_cba_rd_sched;

  localparam int RD_LAT = 2;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dir;
  logic [9:0] cmd_base;
  logic [9:0] cmd_len;
  logic [9:0] cmd_seq_start;
  logic       cmd_l_k_0;
  logic       CB_ena;
  logic [9:0] CB_addra;
  logic [4:0] CB_douta_sel;
  logic [9:0] seq_cnt_out;
  logic       l_k_0;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cba_rd_sched #(
    .CB_AW           (10),
    .SEQ_CNT_DW      (10),
    .CB_DOUTA_SEL_DW (5),
    .RD_LAT          (RD_LAT)
  ) dut (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_dir       (cmd_dir),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .cmd_seq_start (cmd_seq_start),
    .cmd_l_k_0     (cmd_l_k_0),
    .CB_ena        (CB_ena),
    .CB_addra      (CB_addra),
    .CB_douta_sel  (CB_douta_sel),
    .seq_cnt_out   (seq_cnt_out),
    .l_k_0         (l_k_0),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ena"}, 32'(CB_ena), 0);
    chk({tag, "_sel"}, 32'(CB_douta_sel), 0);
    chk({tag, "_seq"}, 32'(seq_cnt_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge (or +1).
  // Cycle c counts clock periods after the accepting edge.
  task automatic run_job(input logic [2:0] op, input logic [1:0] dir,
                         input logic [9:0] base, input logic [9:0] len,
                         input logic [9:0] ss, input logic lk,
                         input bit hold, input int rst_at);
    int done_c;
    int k;
    bit ill;
    bit win;
    ill = (op == 3'b101) || (op == 3'b110);
    done_c = (len == 0) ? 1 : int'(len) + RD_LAT + 1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_dir = dir;
    cmd_base = base;
    cmd_len = len;
    cmd_seq_start = ss;
    cmd_l_k_0 = lk;
    chk("ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    if (hold) begin
      cmd_op = 3'b010;
      cmd_base = 10'h155;
      cmd_len = 10'd7;
      cmd_seq_start = 10'h0AA;
      cmd_l_k_0 = ~lk;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 1; c <= done_c; c++) begin
      k = c - 1 - RD_LAT;
      win = (k >= 0) && (k < int'(len));
      chk("ena", 32'(CB_ena), 32'(c <= int'(len)));
      chk("addr", 32'(CB_addra),
          (c <= int'(len)) ? ((int'(base) + c - 1) % 1024) : 0);
      chk("sel", 32'(CB_douta_sel), (win && !ill) ? 32'({op, dir}) : 0);
      chk("seq", 32'(seq_cnt_out), win ? ((int'(ss) + k) % 1024) : 0);
      chk("done", 32'(done), 32'(c == done_c));
      chk("err", 32'(err), 32'(c == done_c && ill));
      chk("busy", 32'(busy), 1);
      chk("ready_busy", 32'(cmd_ready), 0);
      chk("lk", 32'(l_k_0), 32'(lk));
      if (c == rst_at) begin
        sys_rst = 1'b1;
        #1;
        chk("ready_in_rst", 32'(cmd_ready), 0);
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_ready", 32'(cmd_ready), 1);
        chk("rst_mid_lk", 32'(l_k_0), 0);
        for (int j = 0; j < RD_LAT + 2; j++) begin
          @(negedge clk);
          chk_quiet("rst_after");
        end
        return;
      end
      @(negedge clk);
    end
    chk("busy_end", 32'(busy), 0);
    chk("done_end", 32'(done), 0);
    chk("ready_end", 32'(cmd_ready), 1);
  endtask

  initial begin
    sys_rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_dir = '0;
    cmd_base = '0;
    cmd_len = '0;
    cmd_seq_start = '0;
    cmd_l_k_0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_ready", 32'(cmd_ready), 0);
    chk("reset_lk", 32'(l_k_0), 0);
    chk("reset_addr", 32'(CB_addra), 0);
    sys_rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 1);
    @(negedge clk);

    run_job(3'b001, 2'b01, 10'h010, 10'd4, 10'd0, 1'b0, 1'b0, 0);
    run_job(3'b111, 2'b00, 10'h123, 10'd5, 10'd7, 1'b1, 1'b0, 0);
    run_job(3'b011, 2'b10, 10'h040, 10'd0, 10'd3, 1'b0, 1'b0, 0);
    run_job(3'b101, 2'b01, 10'h200, 10'd2, 10'd9, 1'b1, 1'b0, 0);
    run_job(3'b110, 2'b11, 10'h201, 10'd0, 10'd1, 1'b0, 1'b0, 0);
    run_job(3'b010, 2'b10, 10'h080, 10'd4, 10'd20, 1'b1, 1'b0, 3);
    run_job(3'b100, 2'b11, 10'h3FE, 10'd4, 10'h3FF, 1'b1, 1'b1, 0);
    // The held offer is accepted here, in IDLE, with these fields.
    run_job(3'b001, 2'b10, 10'h155, 10'd3, 10'd5, 1'b0, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      run_job(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              10'($urandom), 10'($urandom_range(0, 12)), 10'($urandom),
              1'($urandom), 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
